// File: rtl/string_hw_pkg.sv
// Shared definitions for the string hardware engine: sequencer states,
// sizing constants, control-register layout and the word-count helper.
package string_hw_pkg;

    localparam int MAX_WORDS = 8;
    localparam int IDX_W     = 4;
    localparam int LEN_W     = 8;

    // Control-register bit positions as seen by software on the Avalon side
    localparam int CTRL_START_BIT       = 0;
    localparam int CTRL_ABORT_BIT       = 1;
    localparam int CTRL_DONE_BIT        = 2;
    localparam int CTRL_TIMEOUT_ERR_BIT = 3;
    localparam int CTRL_LEN_LSB         = 8;
    localparam int CTRL_LEN_MSB         = CTRL_LEN_LSB + LEN_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } seq_state_t;

    // Number of 32-bit words covering len characters, clamped to max_words.
    // The +3 is done one bit wider so a full-scale length cannot wrap.
    function automatic logic [LEN_W:0] words_for_len(input logic [LEN_W-1:0] len,
                                                     input logic [LEN_W:0]   max_words);
        logic [LEN_W:0] words;
        words = ({1'b0, len} + (LEN_W+1)'(3)) >> 2'd2;
        if (words > max_words) begin
            words = max_words;
        end else begin
            words = words;
        end
        return words;
    endfunction

endpackage

// File: rtl/string_hw_sequencer.sv
// Word-level sequencer: walks the StringA/StringB word registers, hands one
// word pair at a time to the String_HW engine and stops on the first non-zero
// engine result, after the last word covered by length, or on engine timeout.
module string_hw_sequencer #(
    parameter int MAX_WORDS = 8,
    parameter int IDX_W     = 4,
    parameter int LEN_W     = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [31:0]      result_out,
    output logic [IDX_W-1:0] stop_index,
    output logic [IDX_W-1:0] word_addr,
    input  logic [31:0]      a_word,
    input  logic [31:0]      b_word,
    output logic             eng_go,
    output logic [IDX_W-1:0] eng_index,
    output logic [LEN_W-1:0] eng_length,
    output logic [31:0]      eng_A,
    output logic [31:0]      eng_B,
    input  logic             eng_done,
    input  logic [31:0]      eng_result
);
    import string_hw_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_t       state_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] last_idx_r;
    logic [LEN_W-1:0] len_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             timeout_err_r;
    logic             eng_go_r;
    logic [31:0]      result_r;
    logic [IDX_W-1:0] stop_r;
    logic [31:0]      eng_a_r;
    logic [31:0]      eng_b_r;

    logic [LEN_W:0]   nwords_s;
    logic [IDX_W-1:0] start_last_idx_s;
    logic             last_word_s;
    logic             timeout_hit_s;

    // Word count for the length offered with start, plus per-cycle stop tests
    always_comb begin
        nwords_s         = words_for_len(length, (LEN_W+1)'(MAX_WORDS));
        start_last_idx_s = IDX_W'(nwords_s - (LEN_W+1)'(1));
        last_word_s      = (idx_r == last_idx_r);
        timeout_hit_s    = (cnt_r == CNT_W'(TIMEOUT - 1));
    end

    // Sequencer FSM with all outputs registered; abort overrides any transition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            idx_r         <= {IDX_W{1'b0}};
            last_idx_r    <= {IDX_W{1'b0}};
            len_r         <= {LEN_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            eng_go_r      <= 1'b0;
            result_r      <= 32'd0;
            stop_r        <= {IDX_W{1'b0}};
            eng_a_r       <= 32'd0;
            eng_b_r       <= 32'd0;
        end else if (abort && (state_r != IDLE)) begin
            // done was cleared when this run started and stays clear
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            eng_go_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r         <= length;
                        last_idx_r    <= start_last_idx_s;
                        idx_r         <= {IDX_W{1'b0}};
                        timeout_err_r <= 1'b0;
                        result_r      <= 32'd0;
                        stop_r        <= {IDX_W{1'b0}};
                        // An empty string completes immediately without the engine
                        done_r        <= (nwords_s == {(LEN_W+1){1'b0}});
                        if (nwords_s != {(LEN_W+1){1'b0}}) begin
                            state_r <= FETCH;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    // Read data is combinational for word_addr == idx
                    eng_a_r  <= a_word;
                    eng_b_r  <= b_word;
                    eng_go_r <= 1'b1;
                    state_r  <= ISSUE;
                end
                ISSUE: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        result_r <= eng_result;
                        stop_r   <= idx_r;
                        eng_go_r <= 1'b0;
                        if ((eng_result != 32'd0) || last_word_s) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            idx_r   <= idx_r + IDX_W'(1);
                            state_r <= FETCH;
                        end
                    end else if (timeout_hit_s) begin
                        timeout_err_r <= 1'b1;
                        done_r        <= 1'b1;
                        busy_r        <= 1'b0;
                        eng_go_r      <= 1'b0;
                        state_r       <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    eng_go_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign timeout_err = timeout_err_r;
    assign result_out  = result_r;
    assign stop_index  = stop_r;
    assign word_addr   = idx_r;
    assign eng_go      = eng_go_r;
    assign eng_index   = idx_r;
    assign eng_length  = len_r;
    assign eng_A       = eng_a_r;
    assign eng_B       = eng_b_r;

endmodule

// File: tb/tb_string_hw_sequencer.sv
// Scoreboard bench for string_hw_sequencer: a behavioural engine and register
// file drive the DUT; expected word issues and completions are queued at
// stimulus time and checked by an independent monitor.
module tb_string_hw_sequencer;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [31:0] result_out;
    logic [3:0]  stop_index;
    logic [3:0]  word_addr;
    logic [31:0] a_word;
    logic [31:0] b_word;
    logic        eng_go;
    logic [3:0]  eng_index;
    logic [7:0]  eng_length;
    logic [31:0] eng_A;
    logic [31:0] eng_B;
    logic        eng_done;
    logic [31:0] eng_result;

    logic [31:0] ra [8];
    logic [31:0] rb [8];
    logic [31:0] eng_res [8];
    int          eng_lat [8];

    int cyc = 0;
    int checks = 0;
    int fails = 0;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  len;
    } go_t;

    typedef struct {
        logic        to;
        logic [31:0] res;
        int          stop;
        int          busy;
        int          cyc;
    } txn_t;

    go_t  go_q [$];
    txn_t sb_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign a_word = ra[word_addr[2:0]];
    assign b_word = rb[word_addr[2:0]];

    string_hw_sequencer #(
        .MAX_WORDS(8), .IDX_W(4), .LEN_W(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .length(length),
        .busy(busy), .done(done), .timeout_err(timeout_err), .result_out(result_out),
        .stop_index(stop_index), .word_addr(word_addr), .a_word(a_word), .b_word(b_word),
        .eng_go(eng_go), .eng_index(eng_index), .eng_length(eng_length),
        .eng_A(eng_A), .eng_B(eng_B), .eng_done(eng_done), .eng_result(eng_result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Engine model: answers lat cycles after go rises, junk result otherwise
    initial begin
        int go_cnt = 0;
        eng_done   = 1'b0;
        eng_result = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (eng_go) go_cnt++;
            else go_cnt = 0;
            if (eng_go && (go_cnt == eng_lat[eng_index[2:0]] + 1)) begin
                eng_done   = 1'b1;
                eng_result = eng_res[eng_index[2:0]];
            end else begin
                eng_done   = 1'b0;
                eng_result = $urandom;
            end
        end
    end

    // Monitor: checks each go rise and each completion against the queues
    initial begin
        logic pd = 1'b0;
        logic pa = 1'b0;
        logic pg = 1'b0;
        int   bc = 0;
        go_t  g;
        txn_t t;
        forever begin
            @(negedge clk);
            if (eng_go && !pg) begin
                if (go_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL go_unexpected: eng_index=%0d issued, none expected", eng_index);
                end else begin
                    g = go_q.pop_front();
                    check("go_index", 64'(eng_index), 64'(g.idx));
                    check("go_A", 64'(eng_A), 64'(g.a));
                    check("go_B", 64'(eng_B), 64'(g.b));
                    check("go_length", 64'(eng_length), 64'(g.len));
                end
            end
            if (done && (!pd || pa)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL done_unexpected: completion seen, none expected");
                end else begin
                    t = sb_q.pop_front();
                    check("timeout_err", 64'(timeout_err), 64'(t.to));
                    check("result_out", 64'(result_out), 64'(t.res));
                    check("stop_index", 64'(stop_index), 64'(t.stop));
                    check("done_cycle", 64'(cyc), 64'(t.cyc));
                    check("busy_cycles", 64'(bc), 64'(t.busy));
                    check("busy_at_done", 64'(busy), 64'd0);
                    check("go_at_done", 64'(eng_go), 64'd0);
                end
            end
            pa = start && !busy && reset_n;
            pd = done;
            pg = eng_go;
            if (busy) bc++;
            else bc = 0;
        end
    end

    task automatic fill(input int lat_lo, input int lat_hi, input int nz_pct);
        for (int i = 0; i < 8; i++) begin
            ra[i]      = $urandom;
            rb[i]      = $urandom;
            eng_lat[i] = int'($urandom_range(lat_hi, lat_lo));
            eng_res[i] = (int'($urandom_range(99, 0)) < nz_pct) ? ($urandom | 32'd1) : 32'd0;
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_wait", 64'(done), 64'd1);
    endtask

    task automatic pulse_start(input logic [7:0] len);
        @(posedge clk);
        #1;
        length = len;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Reference: walk the words as the engine would answer them
    task automatic issue(input logic [7:0] len);
        txn_t t;
        go_t  g;
        int   nw;
        nw = (int'(len) + 3) / 4;
        if (nw > 8) nw = 8;
        t.to = 1'b0; t.res = 32'd0; t.stop = 0; t.busy = 0; t.cyc = 0;
        for (int i = 0; i < nw; i++) begin
            g.idx = i; g.a = ra[i]; g.b = rb[i]; g.len = len;
            go_q.push_back(g);
            if (eng_lat[i] > TIMEOUT) begin
                t.to   = 1'b1;
                t.busy += 2 + TIMEOUT;
                break;
            end
            t.busy += 2 + eng_lat[i];
            t.stop = i;
            t.res  = eng_res[i];
            if (eng_res[i] != 32'd0) break;
        end
        @(posedge clk);
        #1;
        length = len;
        start  = 1'b1;
        t.cyc  = cyc + 1 + t.busy;
        sb_q.push_back(t);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        check({tag, "_result_out"}, 64'(result_out), 64'd0);
        check({tag, "_stop_index"}, 64'(stop_index), 64'd0);
        check({tag, "_word_addr"}, 64'(word_addr), 64'd0);
        check({tag, "_eng_go"}, 64'(eng_go), 64'd0);
        check({tag, "_eng_index"}, 64'(eng_index), 64'd0);
        check({tag, "_eng_length"}, 64'(eng_length), 64'd0);
        check({tag, "_eng_A"}, 64'(eng_A), 64'd0);
        check({tag, "_eng_B"}, 64'(eng_B), 64'd0);
    endtask

    initial begin
        go_t g;
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        length  = 8'd0;
        fill(1, 4, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Three zero-result words, engine latency 3
        fill(3, 3, 0);
        issue(8'd12);

        // Non-zero result on word 2 ends the walk early
        fill(1, 4, 0);
        eng_res[2] = 32'h0000_0001;
        issue(8'd32);

        // Zero length, partial word, and clamp to the register file size
        fill(1, 4, 0);
        issue(8'd0);
        issue(8'd5);
        issue(8'd255);

        // Engine never answers word 0
        fill(1, 4, 0);
        eng_lat[0] = 1000;
        issue(8'd4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("go_after_timeout", 64'(eng_go), 64'd0);
        end

        // Ignored start in WAIT of word 1, then abort
        fill(2, 2, 0);
        eng_lat[1] = 1000;
        for (int i = 0; i < 2; i++) begin
            g.idx = i; g.a = ra[i]; g.b = rb[i]; g.len = 8'd16;
            go_q.push_back(g);
        end
        pulse_start(8'd16);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (eng_go && (eng_index == 4'd1)) break;
        end
        check("reach_word1", 64'(eng_index), 64'd1);
        pulse_start(8'd77);
        length = 8'd16;
        @(negedge clk);
        check("busy_start_busy", 64'(busy), 64'd1);
        check("busy_start_index", 64'(eng_index), 64'd1);
        check("busy_start_length", 64'(eng_length), 64'd16);
        check("busy_start_go", 64'(eng_go), 64'd1);
        check("busy_start_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_go", 64'(eng_go), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (5) @(negedge clk);
        check("abort_go_q", 64'(go_q.size()), 64'd0);
        check("abort_done_later", 64'(done), 64'd0);

        // Asynchronous reset in WAIT, then a normal one-word run
        fill(2, 2, 0);
        eng_lat[0] = 1000;
        g.idx = 0; g.a = ra[0]; g.b = rb[0]; g.len = 8'd8;
        go_q.push_back(g);
        pulse_start(8'd8);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (eng_go) break;
        end
        check("reset_reach_wait", 64'(eng_go), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        fill(2, 2, 0);
        issue(8'd4);

        // Randomised runs
        repeat (40) begin
            fill(1, 5, 25);
            if ($urandom_range(1, 0) == 1) issue(8'($urandom_range(40, 0)));
            else issue(8'($urandom_range(255, 0)));
        end

        repeat (5) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("go_drained", 64'(go_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/string_hw_sequencer.md
# string_hw_sequencer

Word-level sequencer for the string hardware engine. On a start command it walks the A/B string word registers from word 0, feeds one word pair at a time to the `String_HW` engine, and waits for the engine's `done` handshake. It stops at the first word whose engine result is non-zero, or after the last word covered by `length`. It sits between the Avalon register file (control register plus StringA/StringB words) and the engine instance, replacing software-driven per-word sequencing.

## Interface
Parameters:
- `MAX_WORDS`, 8: words per string held in the register file.
- `IDX_W`, 4: width of word index (must hold MAX_WORDS-1).
- `LEN_W`, 8: width of character length.
- `TIMEOUT`, 255: maximum WAIT cycles per word before abort-with-error.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle command pulse; ignored unless IDLE.
- `abort`  in  1  software abort; returns to IDLE.
- `length`  in  LEN_W  string length in characters, sampled on accepted `start`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  sticky completion flag; cleared on accepted `start`.
- `timeout_err`  out  1  sticky; set when engine failed to answer; cleared on accepted `start`.
- `result_out`  out  32  engine result of the stopping word (0 if all words returned 0).
- `stop_index`  out  IDX_W  index of the stopping word.
- `word_addr`  out  IDX_W  read address into StringA/StringB.
- `a_word`, `b_word`  in  32  combinational register-file read data for `word_addr`.
- `eng_go`  out  1  engine go, level handshake.
- `eng_index`  out  IDX_W  current word index to engine.
- `eng_length`  out  LEN_W  latched `length`.
- `eng_A`, `eng_B`  out  32  registered word pair.
- `eng_done`  in  1  engine completion.
- `eng_result`  in  32  engine result, valid while `eng_done` is high.

## Operation
- Word count: `nwords = (length + 3) >> 2`, computed in LEN_W+1 bits, clamped to MAX_WORDS.
- States are IDLE, FETCH, ISSUE, WAIT.
- IDLE: on `start`, latch length, clear `done`, `timeout_err`, `result_out` and `stop_index`, and set idx=0.
  - If nwords==0: set `done` next cycle, stay IDLE, no `eng_go`.
  - Otherwise go to FETCH.
- FETCH: `word_addr`=idx; register `a_word`/`b_word` into `eng_A`/`eng_B`; go to ISSUE. `eng_go` is low, which guarantees at least one low cycle between words.
- ISSUE: `eng_go`=1; clear the WAIT counter; go to WAIT.
- WAIT: `eng_go` held at 1; counter increments. `eng_done` is sampled only in WAIT.
  - On `eng_done`=1: latch `result_out`=`eng_result` and `stop_index`=idx.
    - If `eng_result`≠0 or idx==nwords-1: set `done`, go to IDLE.
    - Else: idx+1, go to FETCH.
  - If counter reaches TIMEOUT without `eng_done`: set `timeout_err` and `done`, go to IDLE.
- `abort` (any non-IDLE state) has priority over every transition: go to IDLE next cycle, drop `eng_go`, leave `done` clear.
- `start` while busy is ignored, with no side effects.
- `eng_index` always equals idx; `eng_length` equals the latched length.

## Timing
- Reset values: every output is 0; state is IDLE; idx is 0; `eng_A`/`eng_B` are 0.
- Reset asserted mid-operation: `eng_go` drops asynchronously; there is no completion and `done` stays 0.
- Per word: FETCH(1) + ISSUE(1) + WAIT(k) cycles, where k≥1 is the cycle count until `eng_done` is sampled high.
- Accepted `start` at cycle 0 gives FETCH in cycle 1 and `eng_go` rising in cycle 2.
- `done`, `result_out` and `stop_index` update in the cycle after the final WAIT cycle; `busy` falls in the same cycle.
- Zero length: `done`=1 in cycle 1; `busy` never rises.
- Timeout: `timeout_err` rises TIMEOUT+1 cycles after ISSUE.

## Structure
- Shared package `string_hw_pkg`:
  - `seq_state_t` enum (IDLE, FETCH, ISSUE, WAIT).
  - `MAX_WORDS`, `IDX_W` and `LEN_W` constants.
  - Control-register bit-field positions for start, abort, done, timeout_err and length.
- Single module; no sub-module needed. The word-count/clamp arithmetic is a package function `words_for_len()`.

## Test plan
- length=12, engine model answers `eng_done` 3 cycles after `eng_go` rises with result 0 for all words:
  - 3 go pulses with `eng_index` 0,1,2.
  - `done`=1 with `result_out`=0 and `stop_index`=2.
  - `busy` high for exactly 3×5=15 cycles.
- length=32, engine returns 0x0000_0001 on word 2:
  - Sequence stops after word 2: `stop_index`=2, `result_out`=1.
  - No `eng_go` for word 3.
- length=0 → `done`=1 in cycle 1, `eng_go` never asserted. length=5 → exactly 2 words. length=255 → clamped to 8 words.
- Engine never answers → `timeout_err`=1 and `done`=1 at ISSUE+256 cycles; `eng_go` low afterward.
- `start` pulsed during WAIT of word 1 → ignored, idx unchanged. `abort` during WAIT → IDLE next cycle with `done`=0.
- `reset_n` low mid-WAIT → all outputs 0 immediately. A following `start` with length=4 completes normally with 1 word.
